alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter that shares one instance of the team's 64-bit combinational ALU between two requesters, such as the execute stage and a multi-cycle address/branch helper. Each port uses a valid/ready request channel. A single registered response stage returns the result, the four flags and the winning port id over a valid/ready response channel. The arbiter owns the ALU control select and sequences one operation per cycle at full throughput.

## Interface
- No parameters: data width fixed at 64, port count fixed at 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: port 0 request valid.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_a`, `req0_b` in 64: port 0 operands.
- `req0_cntrl` in 3: port 0 opcode.
  - 000 = pass B, 010 = A+B, 011 = A−B, 100 = AND, 101 = OR, 110 = XOR.
  - 001 and 111 are unused.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cntrl`: same as port 0, for port 1.
- `rsp_valid` out 1: response stage holds a result.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out 1: port that issued the response.
- `rsp_result` out 64: ALU result.
- `rsp_negative`, `rsp_zero`, `rsp_overflow`, `rsp_carry_out` out 1 each: ALU flags for the operation.
- `rsp_err` out 1: illegal opcode indication (see Configuration).

## Operation
- Grant logic:
  - Register `last_grant` (1 bit), reset value 1, so port 0 wins the first conflict.
  - Only port X valid: grant X.
  - Both valid: grant the port ≠ `last_grant`.
  - `last_grant` updates only on an accepted transfer.
- Stage free: `stage_free = !rsp_valid | rsp_ready`.
- Ready rules:
  - `reqN_ready = grantN & stage_free`.
  - Ready may depend combinationally on valid.
  - At most one ready is high per cycle.
- ALU operands are muxed from the granted port. When nothing is granted, the ALU inputs are port 0's fields; the result is unused.
- On accept, the response stage captures:
  - the ALU result and the four flags,
  - the granted id,
  - `rsp_err`.
- Response hold: once `rsp_valid` is high, all `rsp_*` outputs hold stable until `rsp_ready`.
- Simultaneous events, all in one cycle:
  - Stage full, `rsp_ready` high and a new request: response drains and the new one loads. No bubble.
  - Stage full, `rsp_ready` low: both `reqN_ready` low, requesters hold.
  - Stage drains with no request: `rsp_valid` falls next cycle.
- Flags pass through unmodified from the ALU:
  - pass/AND/OR/XOR: `overflow` and `carry_out` are 0.
  - sub: `carry_out` = 1 when no borrow (A ≥ B unsigned).
- Fairness: with both ports continuously valid and `rsp_ready` held high, grants alternate strictly 0,1,0,1…
- Starvation bound: a waiting port is served within 2 accepted transfers.

## Timing
- Latency: request accepted at edge N gives `rsp_valid` high after edge N, visible in cycle N+1.
- Throughput: 1 op/cycle while `rsp_ready` stays high.
- Reset values:
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0.
  - All flags = 0, `rsp_err` = 0, `last_grant` = 1.
  - `req0_ready` and `req1_ready` are 0 during the reset cycle.
- Reset mid-operation: a pending response is discarded without handshake, and no request is accepted in the reset cycle.
- Request side: no registers. The ALU path is combinational from the request mux to the response register, a single-cycle path.

## Configuration
- `ALU_ARB_ILLEGAL_CHK_EN` defined:
  - Opcodes 001/111 are still accepted and arbitrated normally.
  - Response has `rsp_err` = 1, `rsp_result` = 0 and all flags 0.
  - `last_grant` updates as usual.
- `ALU_ARB_ILLEGAL_CHK_EN` undefined:
  - `rsp_err` is tied 0.
  - 001/111 return whatever the ALU produces, which is result 0 and all flags 0.

## Test plan
- Reset, then port 0 only: a=5, b=3, cntrl=010 → next cycle `rsp_valid`=1, id=0, result=8, zero=0, negative=0, carry_out=0.
- Both ports valid every cycle with `rsp_ready`=1:
  - port 0 sub a=3, b=3.
  - port 1 XOR a=0xFF, b=0x0F.
  - → ids alternate 0,1,0,1.
  - Port 0 responses: result 0, zero=1, carry_out=1.
  - Port 1 responses: result 0xF0.
- Backpressure: hold `rsp_ready`=0 for 4 cycles with both ports valid → both readies 0, response fields stable. Release → one transfer per cycle, no lost or duplicated ops.
- Overflow: port 1 add a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result 0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0.
- Illegal op, port 0 cntrl=111:
  - with `ALU_ARB_ILLEGAL_CHK_EN` → rsp_err=1, result=0.
  - without → rsp_err=0, result=0.
- Assert `reset` while `rsp_valid`=1 and `rsp_ready`=0 → next cycle `rsp_valid`=0. First conflict after release is granted to port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 64-bit combinational ALU between two requesters using
// round-robin arbitration. Each requester presents a valid/ready request
// channel. One registered response stage returns the result, four flags,
// the winning port id and an illegal-opcode indication over a valid/ready
// response channel. It sustains one operation per cycle.
//
// Ports
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   req0_valid / req0_ready    : port 0 request handshake
//   req0_a, req0_b (64)        : port 0 operands
//   req0_cntrl (3)             : port 0 opcode (000 pass B, 010 add, 011 sub,
//                                100 AND, 101 OR, 110 XOR; 001/111 unused)
//   req1_*                     : the same set for port 1
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : port that issued the response
//   rsp_result (64)            : ALU result
//   rsp_negative, rsp_zero,
//   rsp_overflow, rsp_carry_out: ALU flags
//   rsp_err                    : illegal opcode indication
//
// Build option
//   ALU_ARB_ILLEGAL_CHK_EN : when defined, opcodes 001/111 respond with
//                            rsp_err=1, result 0 and all flags 0. When it is
//                            undefined, rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic [2:0]  req0_cntrl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic [2:0]  req1_cntrl,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [63:0] rsp_result,
   output logic        rsp_negative,
   output logic        rsp_zero,
   output logic        rsp_overflow,
   output logic        rsp_carry_out,
   output logic        rsp_err
);

   typedef struct packed {
      logic [63:0] result;
      logic        negative;
      logic        zero;
      logic        overflow;
      logic        carry_out;
   } alu_out_t;

   function automatic logic op_legal(input logic [2:0] cntrl);
      case (cntrl)
         3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110: op_legal = 1'b1;
         default:                                       op_legal = 1'b0;
      endcase
   endfunction

   // Combinational ALU. Unused opcodes yield result 0 with every flag 0
   // (including zero), which is what the shared ALU does.
   function automatic alu_out_t alu_eval(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [2:0]  cntrl);
      alu_out_t           o;
      logic [64:0]        sum;
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sr;
      o   = '0;
      sum = '0;
      sa  = signed'(a);
      sb  = signed'(b);
      case (cntrl)
         3'b000: o.result = b;
         3'b010: begin
            sum         = {1'b0, a} + {1'b0, b};
            o.result    = sum[63:0];
            o.carry_out = sum[64];
            sr          = signed'(sum[63:0]);
            o.overflow  = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
         end
         3'b011: begin
            // a + ~b + 1: the carry out is the "no borrow" indication
            sum         = {1'b0, a} + {1'b0, ~b} + 65'd1;
            o.result    = sum[63:0];
            o.carry_out = sum[64];
            sr          = signed'(sum[63:0]);
            o.overflow  = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
         end
         3'b100: o.result = a & b;
         3'b101: o.result = a | b;
         3'b110: o.result = a ^ b;
         default: o = '0;
      endcase
      if (op_legal(cntrl)) begin
         o.negative = o.result[63];
         o.zero     = (o.result == 64'd0);
      end
      return o;
   endfunction

   logic        last_grant_q, last_grant_d;
   logic        rsp_valid_q,  rsp_valid_d;
   logic        rsp_id_q,     rsp_id_d;
   alu_out_t    rsp_q,        rsp_d;
   logic        rsp_err_q,    rsp_err_d;

   logic        grant0, grant1, stage_free, accept, illegal;
   logic [63:0] alu_a, alu_b;
   logic [2:0]  alu_cntrl;
   alu_out_t    alu_res;

   // Request side: arbitration, ALU operand mux and the ALU itself
   always_comb begin
      // On a conflict the port that did not win last time is served
      grant0     = req0_valid & (~req1_valid | last_grant_q);
      grant1     = req1_valid & (~req0_valid | ~last_grant_q);
      stage_free = ~rsp_valid_q | rsp_ready;
      req0_ready = grant0 & stage_free & ~reset;
      req1_ready = grant1 & stage_free & ~reset;
      accept     = req0_ready | req1_ready;

      // Port 0 fields feed the ALU when nothing is granted; the result is then ignored
      alu_a      = grant1 ? req1_a     : req0_a;
      alu_b      = grant1 ? req1_b     : req0_b;
      alu_cntrl  = grant1 ? req1_cntrl : req0_cntrl;
      alu_res    = alu_eval(alu_a, alu_b, alu_cntrl);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
      illegal = ~op_legal(alu_cntrl);
      if (illegal) begin
         alu_res = '0;
      end
`else
      illegal = 1'b0;
`endif

      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_d        = rsp_q;
      rsp_err_d    = rsp_err_q;
      if (accept) begin
         last_grant_d = grant1;
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant1;
         rsp_d        = alu_res;
         rsp_err_d    = illegal;
      end else if (rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   // Response stage register
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_q        <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_q        <= rsp_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_result    = rsp_q.result;
   assign rsp_negative  = rsp_q.negative;
   assign rsp_zero      = rsp_q.zero;
   assign rsp_overflow  = rsp_q.overflow;
   assign rsp_carry_out = rsp_q.carry_out;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter: scoreboard bench for alu_arbiter. The driver issues
// requests on the falling edge, predicts which port is accepted and pushes
// the expected response. A monitor pops and compares each response it sees.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_cntrl, req1_cntrl;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [63:0] rsp_result;
   logic        rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cntrl(req0_cntrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cntrl(req1_cntrl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
      .rsp_overflow(rsp_overflow), .rsp_carry_out(rsp_carry_out), .rsp_err(rsp_err)
   );

   typedef struct {
      logic        id;
      logic [63:0] res;
      logic        n, z, v, c, e;
   } rsp_t;

   rsp_t q[$];
   int   checks = 0;
   int   failures = 0;
   logic last_m = 1'b1;
   int   pushed_now = 0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference ALU from the arithmetic definitions, using 65-bit math
   function automatic rsp_t ref_op(input logic id, input logic [63:0] a,
                                   input logic [63:0] b, input logic [2:0] op);
      rsp_t               r;
      logic [64:0]        u;
      logic signed [64:0] s;
      logic               legal;
      r.id = id; r.res = '0; r.n = 0; r.z = 0; r.v = 0; r.c = 0; r.e = 0;
      legal = 1'b1;
      case (op)
         3'b000: r.res = b;
         3'b010: begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[63], a}) + $signed({b[63], b});
            r.res = u[63:0]; r.c = u[64]; r.v = (s[64] != s[63]);
         end
         3'b011: begin
            s = $signed({a[63], a}) - $signed({b[63], b});
            r.res = a - b; r.c = (a >= b); r.v = (s[64] != s[63]);
         end
         3'b100: r.res = a & b;
         3'b101: r.res = a | b;
         3'b110: r.res = a ^ b;
         default: begin legal = 1'b0; r.e = ERR_EXP; end
      endcase
      if (legal) begin
         r.n = r.res[63];
         r.z = (r.res == 64'd0);
      end
      return r;
   endfunction

   // One clock of stimulus; predicts grant/ready and queues expected response
   task automatic cyc(input logic rst, input logic v0, input logic [63:0] a0,
                      input logic [63:0] b0, input logic [2:0] c0,
                      input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                      input logic [2:0] c1, input logic rr);
      logic sf, g0, g1;
      @(negedge clk);
      reset = rst; rsp_ready = rr;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_cntrl = c0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_cntrl = c1;
      #1;
      pushed_now = 0;
      if (rst) begin
         chk("ready0_in_reset", {63'd0, req0_ready}, 64'd0);
         chk("ready1_in_reset", {63'd0, req1_ready}, 64'd0);
         q.delete();
         last_m = 1'b1;
      end else begin
         sf = (q.size() == 0) || rr;
         g0 = v0 && (!v1 || last_m);
         g1 = v1 && (!v0 || !last_m);
         chk("ready0", {63'd0, req0_ready}, {63'd0, g0 && sf});
         chk("ready1", {63'd0, req1_ready}, {63'd0, g1 && sf});
         if (g0 && sf) begin
            q.push_back(ref_op(1'b0, a0, b0, c0)); last_m = 1'b0; pushed_now = 1;
         end else if (g1 && sf) begin
            q.push_back(ref_op(1'b1, a1, b1, c1)); last_m = 1'b1; pushed_now = 1;
         end
      end
   endtask

   task automatic idle(input logic rr);
      cyc(1'b0, 1'b0, 64'd0, 64'd0, 3'b000, 1'b0, 64'd0, 64'd0, 3'b000, rr);
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return '1;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         4: return {32'd0, $urandom()};
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // Monitor: compare the displayed response against the scoreboard head
   initial begin : monitor
      logic        held;
      logic        p_id, p_n, p_z, p_v, p_c, p_e;
      logic [63:0] p_res;
      int          shown;
      rsp_t        e;
      held = 1'b0;
      p_id = 0; p_n = 0; p_z = 0; p_v = 0; p_c = 0; p_e = 0; p_res = '0;
      forever begin
         @(negedge clk);
         #2;
         if (reset === 1'b1) begin
            held = 1'b0;
         end else begin
            shown = q.size() - pushed_now;
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, shown > 0});
            if (held) begin
               chk("hold_id", {63'd0, rsp_id}, {63'd0, p_id});
               chk("hold_result", rsp_result, p_res);
               chk("hold_flags", {59'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err},
                   {59'd0, p_n, p_z, p_v, p_c, p_e});
            end
            if (rsp_valid && shown > 0) begin
               e = q[0];
               chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_flags", {59'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err},
                   {59'd0, e.n, e.z, e.v, e.c, e.e});
               if (rsp_ready) void'(q.pop_front());
            end
            held = rsp_valid && !rsp_ready;
            p_id = rsp_id; p_res = rsp_result; p_n = rsp_negative; p_z = rsp_zero;
            p_v = rsp_overflow; p_c = rsp_carry_out; p_e = rsp_err;
         end
      end
   end

   initial begin : driver
      logic        prev_id;
      logic        rst;
      reset = 1'b1; rsp_ready = 1'b0;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_cntrl = '0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_cntrl = '0;

      cyc(1'b1, 1'b1, 64'd1, 64'd2, 3'b010, 1'b1, 64'd1, 64'd2, 3'b010, 1'b1);
      cyc(1'b1, 1'b0, 64'd0, 64'd0, 3'b000, 1'b0, 64'd0, 64'd0, 3'b000, 1'b1);
      idle(1'b1);
      chk("reset_valid", {63'd0, rsp_valid}, 64'd0);
      chk("reset_id", {63'd0, rsp_id}, 64'd0);
      chk("reset_result", rsp_result, 64'd0);
      chk("reset_flags", {59'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err}, 64'd0);

      // Port 0 alone: 5 + 3
      cyc(1'b0, 1'b1, 64'd5, 64'd3, 3'b010, 1'b0, 64'd0, 64'd0, 3'b000, 1'b1);
      idle(1'b1);
      chk("add_valid", {63'd0, rsp_valid}, 64'd1);
      chk("add_id", {63'd0, rsp_id}, 64'd0);
      chk("add_result", rsp_result, 64'd8);
      chk("add_nzc", {61'd0, rsp_negative, rsp_zero, rsp_carry_out}, 64'd0);

      // Both ports every cycle: strict alternation
      prev_id = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 64'd3, 64'd3, 3'b011, 1'b1, 64'hFF, 64'h0F, 3'b110, 1'b1);
         if (i >= 1) begin
            if (i >= 2) chk("alternate_id", {63'd0, rsp_id}, {63'd0, ~prev_id});
            if (rsp_id == 1'b0) begin
               chk("sub_result", rsp_result, 64'd0);
               chk("sub_zc", {62'd0, rsp_zero, rsp_carry_out}, 64'd3);
            end else begin
               chk("xor_result", rsp_result, 64'hF0);
            end
            prev_id = rsp_id;
         end
      end

      // Backpressure then release
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b1, 64'd10, 64'd4, 3'b011, 1'b1, 64'd6, 64'd7, 3'b010, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b1, 64'd10, 64'd4, 3'b011, 1'b1, 64'd6, 64'd7, 3'b010, 1'b1);
      idle(1'b1);

      // Signed overflow on port 1
      cyc(1'b0, 1'b0, 64'd0, 64'd0, 3'b000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1);
      idle(1'b1);
      chk("ovf_result", rsp_result, 64'h8000_0000_0000_0000);
      chk("ovf_nvc", {61'd0, rsp_negative, rsp_overflow, rsp_carry_out}, 64'd6);

      // Unused opcode on port 0
      cyc(1'b0, 1'b1, 64'h1234, 64'h5678, 3'b111, 1'b0, 64'd0, 64'd0, 3'b000, 1'b1);
      idle(1'b1);
      chk("illegal_err", {63'd0, rsp_err}, {63'd0, ERR_EXP});
      chk("illegal_result", rsp_result, 64'd0);

      // Reset while a response is stalled
      cyc(1'b0, 1'b1, 64'd1, 64'd1, 3'b010, 1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
      cyc(1'b0, 1'b1, 64'd2, 64'd2, 3'b010, 1'b1, 64'd3, 64'd3, 3'b010, 1'b0);
      cyc(1'b1, 1'b1, 64'd2, 64'd2, 3'b010, 1'b1, 64'd3, 64'd3, 3'b010, 1'b0);
      cyc(1'b0, 1'b1, 64'd2, 64'd2, 3'b010, 1'b1, 64'd3, 64'd3, 3'b010, 1'b1);
      chk("post_reset_valid", {63'd0, rsp_valid}, 64'd0);
      chk("post_reset_grant0", {62'd0, req0_ready, req1_ready}, 64'd2);
      idle(1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         cyc(rst, $urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(), 3'($urandom()),
             $urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(), 3'($urandom()),
             $urandom_range(0, 9) < 7);
      end

      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
